// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared encodings and helpers for the memory access stage
package mem_access_stage_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    // Byte offset actually used on the bus: halves and words ignore the low bits.
    function automatic logic [1:0] align_off(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LEN_B:   return off;
            LEN_H:   return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // A half crossing the word boundary or any unaligned word.
    function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LEN_B:   return 1'b0;
            LEN_H:   return off == 2'd3;
            default: return off != 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [1:0] len, input logic [1:0] off);
        case (len)
            LEN_B:   return 4'b0001 << off;
            LEN_H:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// rtl/mem_access_stage_load_align.sv - load data lane extraction and sign/zero extension
module mem_access_stage_load_align
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [1:0]      len,
    input  logic            is_signed,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    // Shift the addressed lane down to bit 0, then extend to full width.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        data    = shifted;
        case (len)
            LEN_B:   data = {{(XLEN-8){is_signed & shifted[7]}}, shifted[7:0]};
            LEN_H:   data = {{(XLEN-16){is_signed & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory access pipeline stage (option: MEM_ACCESS_MISALIGN_TRAP_EN)
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN        = XLEN_DEF,
    parameter int BUS_TIMEOUT = 0
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [4:0]      i_eu_rd,
    input  logic [XLEN-1:0] i_eu_res,
    input  logic            i_eu_read_en,
    input  logic [XLEN-1:0] i_eu_addr_r,
    input  logic [1:0]      i_eu_len_r,
    input  logic            i_eu_is_signed,
    input  logic            i_eu_write_en,
    input  logic [XLEN-1:0] i_eu_addr_w,
    input  logic [XLEN-1:0] i_eu_data_w,
    input  logic [1:0]      i_eu_len_w,
    output logic            o_eu_stall,
    output logic [4:0]      o_eu_bypass_reg,
    output logic [XLEN-1:0] o_eu_bypass_data,
    output logic [4:0]      o_eu_reg_not_ready,
    output logic            o_bus_valid,
    input  logic            i_bus_ready,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_wstrb,
    input  logic            i_bus_rvalid,
    input  logic [XLEN-1:0] i_bus_rdata,
    input  logic            i_bus_err,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_err
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    ,
    output logic [XLEN-1:0] o_misalign_addr
`endif
);

    logic [1:0]      state;
    logic [4:0]      op_rd;
    logic [XLEN-1:0] op_addr;
    logic [XLEN-1:0] op_wdata;
    logic [1:0]      op_len;
    logic            op_we;
    logic            op_signed;
    logic [15:0]     tmo_cnt;

    logic            mem_req;
    logic [XLEN-1:0] sel_addr;
    logic [1:0]      sel_len;
    logic [1:0]      off_eff;
    logic            req_we;
    logic            tmo_hit;
    logic [XLEN-1:0] ld_data;
    logic [XLEN-1:0] wdata_rep;

    // A load wins over a simultaneous store.
    assign mem_req  = (state == ST_IDLE) && (i_eu_read_en || i_eu_write_en);
    assign sel_addr = i_eu_read_en ? i_eu_addr_r : i_eu_addr_w;
    assign sel_len  = i_eu_read_en ? i_eu_len_r : i_eu_len_w;
    assign off_eff  = align_off(op_len, op_addr[1:0]);
    assign tmo_hit  = (BUS_TIMEOUT != 0) && (tmo_cnt == 16'(BUS_TIMEOUT - 1));

    // Replicate store data into every lane so the strobes alone pick the bytes.
    always_comb begin
        case (op_len)
            LEN_B:   wdata_rep = {(XLEN/8){op_wdata[7:0]}};
            LEN_H:   wdata_rep = {(XLEN/16){op_wdata[15:0]}};
            default: wdata_rep = op_wdata;
        endcase
    end

    assign req_we      = (state == ST_REQ) && op_we;
    assign o_bus_valid = (state == ST_REQ);
    assign o_bus_we    = req_we;
    assign o_bus_addr  = o_bus_valid ? {op_addr[XLEN-1:2], 2'b00} : '0;
    assign o_bus_wdata = req_we ? wdata_rep : '0;
    assign o_bus_wstrb = req_we ? lane_strobe(op_len, off_eff) : 4'b0000;

    assign o_eu_stall         = rstn && ((state != ST_IDLE) || mem_req);
    assign o_eu_reg_not_ready = ((state == ST_REQ) || (state == ST_WAIT)) && !op_we ? op_rd : 5'd0;
    assign o_eu_bypass_reg    = o_wb_rd;
    assign o_eu_bypass_data   = o_wb_data;

    mem_access_stage_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata     (i_bus_rdata),
        .off       (off_eff),
        .len       (op_len),
        .is_signed (op_signed),
        .data      (ld_data)
    );

    // Main FSM: captures the op in IDLE, runs the bus handshake, produces write-back.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            op_rd      <= '0;
            op_addr    <= '0;
            op_wdata   <= '0;
            op_len     <= LEN_B;
            op_we      <= 1'b0;
            op_signed  <= 1'b0;
            tmo_cnt    <= '0;
            o_err      <= 1'b0;
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
        end else begin
            o_err      <= 1'b0;
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        op_rd     <= i_eu_rd;
                        op_addr   <= sel_addr;
                        op_len    <= sel_len;
                        op_we     <= !i_eu_read_en;
                        op_signed <= i_eu_is_signed;
                        op_wdata  <= i_eu_data_w;
                        tmo_cnt   <= '0;
                        o_err     <= i_eu_read_en & i_eu_write_en;
                        state     <= ST_REQ;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        if (is_misaligned(sel_len, sel_addr[1:0])) begin
                            state <= ST_TRAP;
                            o_err <= 1'b1;
                        end
`endif
                    end else begin
                        o_wb_valid <= (i_eu_rd != 5'd0);
                        o_wb_rd    <= i_eu_rd;
                        o_wb_data  <= i_eu_res;
                    end
                end
                ST_REQ: begin
                    if (i_bus_ready) begin
                        if (op_we) begin
                            state <= ST_IDLE;
                            o_err <= i_bus_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_bus_rvalid) begin
                        state <= ST_IDLE;
                        if (i_bus_err) begin
                            o_err <= 1'b1;
                        end else begin
                            o_wb_valid <= (op_rd != 5'd0);
                            o_wb_rd    <= op_rd;
                            o_wb_data  <= ld_data;
                        end
                    end else if (tmo_hit) begin
                        state <= ST_IDLE;
                        o_err <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    // Hold the faulting address until the next misaligned access replaces it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_misalign_addr <= '0;
        end else if (mem_req && is_misaligned(sel_len, sel_addr[1:0])) begin
            o_misalign_addr <= sel_addr;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard testbench for mem_access_stage
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [4:0]  i_eu_rd = '0;
    logic [31:0] i_eu_res = '0;
    logic        i_eu_read_en = 1'b0;
    logic [31:0] i_eu_addr_r = '0;
    logic [1:0]  i_eu_len_r = '0;
    logic        i_eu_is_signed = 1'b0;
    logic        i_eu_write_en = 1'b0;
    logic [31:0] i_eu_addr_w = '0;
    logic [31:0] i_eu_data_w = '0;
    logic [1:0]  i_eu_len_w = '0;
    logic        o_eu_stall;
    logic [4:0]  o_eu_bypass_reg;
    logic [31:0] o_eu_bypass_data;
    logic [4:0]  o_eu_reg_not_ready;
    logic        o_bus_valid;
    logic        i_bus_ready = 1'b0;
    logic        o_bus_we;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wdata;
    logic [3:0]  o_bus_wstrb;
    logic        i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = '0;
    logic        i_bus_err = 1'b0;
    logic        o_wb_valid;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_wb_data;
    logic        o_err;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic [31:0] o_misalign_addr;
`endif

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_t;

    wb_t  exp_wb[$];
    bus_t exp_bus[$];
    bit   exp_err[$];

    int checks = 0;
    int errors = 0;

    mem_access_stage #(
        .XLEN(32),
        .BUS_TIMEOUT(0)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .i_eu_rd            (i_eu_rd),
        .i_eu_res           (i_eu_res),
        .i_eu_read_en       (i_eu_read_en),
        .i_eu_addr_r        (i_eu_addr_r),
        .i_eu_len_r         (i_eu_len_r),
        .i_eu_is_signed     (i_eu_is_signed),
        .i_eu_write_en      (i_eu_write_en),
        .i_eu_addr_w        (i_eu_addr_w),
        .i_eu_data_w        (i_eu_data_w),
        .i_eu_len_w         (i_eu_len_w),
        .o_eu_stall         (o_eu_stall),
        .o_eu_bypass_reg    (o_eu_bypass_reg),
        .o_eu_bypass_data   (o_eu_bypass_data),
        .o_eu_reg_not_ready (o_eu_reg_not_ready),
        .o_bus_valid        (o_bus_valid),
        .i_bus_ready        (i_bus_ready),
        .o_bus_we           (o_bus_we),
        .o_bus_addr         (o_bus_addr),
        .o_bus_wdata        (o_bus_wdata),
        .o_bus_wstrb        (o_bus_wstrb),
        .i_bus_rvalid       (i_bus_rvalid),
        .i_bus_rdata        (i_bus_rdata),
        .i_bus_err          (i_bus_err),
        .o_wb_valid         (o_wb_valid),
        .o_wb_rd            (o_wb_rd),
        .o_wb_data          (o_wb_data),
        .o_err              (o_err)
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        ,
        .o_misalign_addr    (o_misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected write-back, error and bus entries as the DUT presents them.
    logic        prev_err = 1'b0;
    logic        bus_pending = 1'b0;
    bus_t        bus_prev;
    always @(negedge clk) begin
        wb_t  w;
        bus_t b;
        if (o_wb_valid) begin
            if (exp_wb.size() == 0) begin
                chk("wb_unexpected", {31'd0, o_wb_valid}, 32'd0);
            end else begin
                w = exp_wb.pop_front();
                chk("wb_rd", {27'd0, o_wb_rd}, {27'd0, w.rd});
                chk("wb_data", o_wb_data, w.data);
                chk("bypass_reg", {27'd0, o_eu_bypass_reg}, {27'd0, w.rd});
                chk("bypass_data", o_eu_bypass_data, w.data);
            end
        end
        if (o_err) begin
            if (exp_err.size() == 0) begin
                chk("err_unexpected", {31'd0, o_err}, 32'd0);
            end else begin
                void'(exp_err.pop_front());
                chk("err_single_pulse", {31'd0, prev_err}, 32'd0);
            end
        end
        prev_err = o_err;
        if (o_bus_valid) begin
            if (bus_pending) begin
                chk("bus_stable_we", {31'd0, o_bus_we}, {31'd0, bus_prev.we});
                chk("bus_stable_addr", o_bus_addr, bus_prev.addr);
                chk("bus_stable_wdata", o_bus_wdata, bus_prev.wdata);
                chk("bus_stable_wstrb", {28'd0, o_bus_wstrb}, {28'd0, bus_prev.wstrb});
            end
            if (i_bus_ready) begin
                bus_pending = 1'b0;
                if (exp_bus.size() == 0) begin
                    chk("bus_unexpected", {31'd0, o_bus_valid}, 32'd0);
                end else begin
                    b = exp_bus.pop_front();
                    chk("bus_we", {31'd0, o_bus_we}, {31'd0, b.we});
                    chk("bus_addr", o_bus_addr, b.addr);
                    chk("bus_wdata", o_bus_wdata, b.wdata);
                    chk("bus_wstrb", {28'd0, o_bus_wstrb}, {28'd0, b.wstrb});
                end
            end else begin
                bus_pending = 1'b1;
                bus_prev.we    = o_bus_we;
                bus_prev.addr  = o_bus_addr;
                bus_prev.wdata = o_bus_wdata;
                bus_prev.wstrb = o_bus_wstrb;
            end
        end else begin
            bus_pending = 1'b0;
        end
    end

    task automatic clear_eu();
        i_eu_rd        = '0;
        i_eu_res       = '0;
        i_eu_read_en   = 1'b0;
        i_eu_write_en  = 1'b0;
        i_eu_addr_r    = '0;
        i_eu_addr_w    = '0;
        i_eu_data_w    = '0;
        i_eu_len_r     = '0;
        i_eu_len_w     = '0;
        i_eu_is_signed = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_stall"}, {31'd0, o_eu_stall}, 32'd0);
        chk({tag, "_bus_valid"}, {31'd0, o_bus_valid}, 32'd0);
        chk({tag, "_wb_valid"}, {31'd0, o_wb_valid}, 32'd0);
        chk({tag, "_wb_rd"}, {27'd0, o_wb_rd}, 32'd0);
        chk({tag, "_wb_data"}, o_wb_data, 32'd0);
        chk({tag, "_err"}, {31'd0, o_err}, 32'd0);
        chk({tag, "_bypass_reg"}, {27'd0, o_eu_bypass_reg}, 32'd0);
        chk({tag, "_not_ready"}, {27'd0, o_eu_reg_not_ready}, 32'd0);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res);
        wb_t w;
        @(posedge clk); #1;
        i_eu_rd  = rd;
        i_eu_res = res;
        if (rd != 5'd0) begin
            w.rd = rd; w.data = res;
            exp_wb.push_back(w);
        end
        @(negedge clk);
        chk("alu_stall", {31'd0, o_eu_stall}, 32'd0);
        @(posedge clk); #1;
        clear_eu();
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [1:0] len,
                           input logic sgn, input logic both, input int rdy_dly, input int rv_dly,
                           input logic [31:0] rdata, input logic err,
                           input logic [31:0] exp_addr, input logic [31:0] exp_data);
        wb_t  w;
        bus_t b;
        @(posedge clk); #1;
        i_eu_rd        = rd;
        i_eu_read_en   = 1'b1;
        i_eu_addr_r    = addr;
        i_eu_len_r     = len;
        i_eu_is_signed = sgn;
        if (both) begin
            i_eu_write_en = 1'b1;
            i_eu_addr_w   = 32'h0000_0080;
            i_eu_data_w   = 32'h0000_0055;
            i_eu_len_w    = LEN_W;
            exp_err.push_back(1'b1);
        end
        b.we = 1'b0; b.addr = exp_addr; b.wdata = 32'd0; b.wstrb = 4'd0;
        exp_bus.push_back(b);
        if (err) exp_err.push_back(1'b1);
        else if (rd != 5'd0) begin
            w.rd = rd; w.data = exp_data;
            exp_wb.push_back(w);
        end
        @(negedge clk);
        chk("ld_stall_accept", {31'd0, o_eu_stall}, 32'd1);
        @(posedge clk); #1;
        clear_eu();
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk("ld_stall_req", {31'd0, o_eu_stall}, 32'd1);
            chk("ld_req_valid", {31'd0, o_bus_valid}, 32'd1);
            chk("ld_not_ready_req", {27'd0, o_eu_reg_not_ready}, {27'd0, rd});
            @(posedge clk); #1;
        end
        i_bus_ready = 1'b1;
        @(negedge clk);
        chk("ld_not_ready_hs", {27'd0, o_eu_reg_not_ready}, {27'd0, rd});
        @(posedge clk); #1;
        i_bus_ready = 1'b0;
        for (int i = 0; i < rv_dly; i++) begin
            @(negedge clk);
            chk("ld_stall_wait", {31'd0, o_eu_stall}, 32'd1);
            chk("ld_not_ready_wait", {27'd0, o_eu_reg_not_ready}, {27'd0, rd});
            @(posedge clk); #1;
        end
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = rdata;
        i_bus_err    = err;
        @(negedge clk);
        chk("ld_stall_rvalid", {31'd0, o_eu_stall}, 32'd1);
        chk("ld_not_ready_exit", {27'd0, o_eu_reg_not_ready}, {27'd0, rd});
        @(posedge clk); #1;
        i_bus_rvalid = 1'b0;
        i_bus_rdata  = '0;
        i_bus_err    = 1'b0;
        @(negedge clk);
        chk("ld_stall_done", {31'd0, o_eu_stall}, 32'd0);
        chk("ld_not_ready_done", {27'd0, o_eu_reg_not_ready}, 32'd0);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] len,
                            input int rdy_dly, input logic [31:0] exp_addr,
                            input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
        bus_t b;
        @(posedge clk); #1;
        i_eu_write_en = 1'b1;
        i_eu_addr_w   = addr;
        i_eu_data_w   = data;
        i_eu_len_w    = len;
        b.we = 1'b1; b.addr = exp_addr; b.wdata = exp_wdata; b.wstrb = exp_strb;
        exp_bus.push_back(b);
        @(negedge clk);
        chk("st_stall_accept", {31'd0, o_eu_stall}, 32'd1);
        @(posedge clk); #1;
        clear_eu();
        for (int i = 0; i < rdy_dly; i++) begin
            @(negedge clk);
            chk("st_stall_req", {31'd0, o_eu_stall}, 32'd1);
            chk("st_not_ready", {27'd0, o_eu_reg_not_ready}, 32'd0);
            @(posedge clk); #1;
        end
        i_bus_ready = 1'b1;
        @(negedge clk);
        chk("st_stall_hs", {31'd0, o_eu_stall}, 32'd1);
        @(posedge clk); #1;
        i_bus_ready = 1'b0;
        @(negedge clk);
        chk("st_stall_after_ready", {31'd0, o_eu_stall}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rstn = 1'b0;
        #3;
        check_idle_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;

        alu(5'd5, 32'h0000_1234);
        alu(5'd0, 32'h0000_DEAD);
        alu(5'd31, 32'hFFFF_FFFF);

        do_load(5'd7, 32'h0000_0103, LEN_B, 1'b1, 1'b0, 2, 3, 32'h80FF_FF7F, 1'b0,
                32'h0000_0100, 32'hFFFF_FF80);
        do_load(5'd8, 32'h0000_0202, LEN_H, 1'b0, 1'b0, 0, 0, 32'hBEEF_0000, 1'b0,
                32'h0000_0200, 32'h0000_BEEF);
        do_load(5'd13, 32'h0000_0051, LEN_B, 1'b0, 1'b0, 1, 1, 32'h0000_8000, 1'b0,
                32'h0000_0050, 32'h0000_0080);
        do_load(5'd14, 32'h0000_0060, LEN_H, 1'b1, 1'b0, 0, 1, 32'h0000_8001, 1'b0,
                32'h0000_0060, 32'hFFFF_8001);

        do_store(32'h0000_0006, 32'h0000_ABCD, LEN_H, 1, 32'h0000_0004, 32'hABCD_ABCD, 4'b1100);
        do_store(32'h0000_0011, 32'h0000_005A, LEN_B, 0, 32'h0000_0010, 32'h5A5A_5A5A, 4'b0010);
        do_store(32'h0000_0020, 32'h1122_3344, LEN_W, 2, 32'h0000_0020, 32'h1122_3344, 4'b1111);

        do_load(5'd9, 32'h0000_0040, LEN_W, 1'b0, 1'b0, 0, 1, 32'h1234_5678, 1'b1,
                32'h0000_0040, 32'h0);
        do_load(5'd0, 32'h0000_0044, LEN_W, 1'b0, 1'b0, 0, 0, 32'h9999_9999, 1'b0,
                32'h0000_0044, 32'h0);
        do_load(5'd10, 32'h0000_0048, LEN_W, 1'b0, 1'b1, 1, 0, 32'hCAFE_BABE, 1'b0,
                32'h0000_0048, 32'hCAFE_BABE);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        @(posedge clk); #1;
        i_eu_rd      = 5'd11;
        i_eu_read_en = 1'b1;
        i_eu_addr_r  = 32'h0000_0003;
        i_eu_len_r   = LEN_W;
        exp_err.push_back(1'b1);
        @(negedge clk);
        chk("trap_stall_accept", {31'd0, o_eu_stall}, 32'd1);
        @(posedge clk); #1;
        clear_eu();
        @(negedge clk);
        chk("trap_stall", {31'd0, o_eu_stall}, 32'd1);
        chk("trap_no_bus", {31'd0, o_bus_valid}, 32'd0);
        chk("trap_err", {31'd0, o_err}, 32'd1);
        chk("trap_addr", o_misalign_addr, 32'h0000_0003);
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_stall_done", {31'd0, o_eu_stall}, 32'd0);
`else
        do_load(5'd11, 32'h0000_0003, LEN_W, 1'b0, 1'b0, 0, 0, 32'h0102_0304, 1'b0,
                32'h0000_0000, 32'h0102_0304);
`endif

        begin
            bus_t b;
            @(posedge clk); #1;
            i_eu_rd      = 5'd12;
            i_eu_read_en = 1'b1;
            i_eu_addr_r  = 32'h0000_0070;
            i_eu_len_r   = LEN_W;
            b.we = 1'b0; b.addr = 32'h0000_0070; b.wdata = 32'd0; b.wstrb = 4'd0;
            exp_bus.push_back(b);
            @(posedge clk); #1;
            clear_eu();
            i_bus_ready = 1'b1;
            @(posedge clk); #1;
            i_bus_ready = 1'b0;
            @(negedge clk);
            chk("rst_wait_not_ready", {27'd0, o_eu_reg_not_ready}, 32'd12);
            chk("rst_wait_stall", {31'd0, o_eu_stall}, 32'd1);
            #2 rstn = 1'b0;
            #1;
            check_idle_outputs("midrst");
            @(negedge clk);
            rstn = 1'b1;
        end

        alu(5'd3, 32'h0000_0077);

        repeat (3) @(negedge clk);
        chk("wb_queue_drained", exp_wb.size(), 32'd0);
        chk("bus_queue_drained", exp_bus.size(), 32'd0);
        chk("err_queue_drained", exp_err.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
